conv2_k_mem_write: RTL and testbench

//  Loader for the Convolution 2 kernel weight memory. Host-supplied weights arrive on a valid/ready stream.

---
 rtl/conv2_k_mem_write.sv | 171 +++++++++++++++++
 tb/tb_conv2_k_mem_write.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/conv2_k_mem_write.sv
// Purpose: streams host weights into the conv2 kernel RAM. Kernel k, tap t is written at k*KSIZE + t.
// Latency: one cycle from an accepted word to its wr_en/wr_addr/wr_data; done rises one cycle after the final write.
// Backpressure: in_ready is high only while loading and depends on state alone; a low in_valid holds progress.
// Optional feature: define KMEM_CHECKSUM_EN to build the 16-bit running checksum. Otherwise checksum is tied to zero.
module conv2_k_mem_write #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int KSIZE    = 25,
    parameter int NKERNELS = 6
) (
    input  logic              clk,
    input  logic              reset,      // active-low, asynchronous
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              done,
    output logic [15:0]       checksum
);

    localparam int TAP_W  = (KSIZE > 1)    ? $clog2(KSIZE)    : 1;
    localparam int KERN_W = (NKERNELS > 1) ? $clog2(NKERNELS) : 1;

    localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(KSIZE - 1);
    localparam logic [KERN_W-1:0] KERN_LAST = KERN_W'(NKERNELS - 1);
    localparam logic [ADDR_W-1:0] KSIZE_A   = ADDR_W'(KSIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    logic [KERN_W-1:0] kern_q, kern_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              done_q, done_d;

    logic              accept;
    logic              last_word;
    logic [ADDR_W-1:0] cur_addr;

`ifdef KMEM_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;
`endif

    // Ready is a pure function of state so the host never sees a combinational loop through in_valid.
    assign in_ready = (state_q == S_LOAD);

    // Address of the word being offered this cycle; sized so the full load fits without wrapping.
    always_comb begin
        accept    = in_valid && (state_q == S_LOAD);
        last_word = (kern_q == KERN_LAST) && (tap_q == TAP_LAST);
        cur_addr  = ADDR_W'(kern_q) * KSIZE_A + ADDR_W'(tap_q);
    end

    // Next-state logic: load sequencing, write strobe generation and done flag.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        kern_d    = kern_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
`ifdef KMEM_CHECKSUM_EN
        checksum_d = checksum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    tap_d   = '0;
                    kern_d  = '0;
`ifdef KMEM_CHECKSUM_EN
                    checksum_d = 16'h0000;
`endif
                end
            end

            S_LOAD: begin
                // start is deliberately ignored here so a stray pulse cannot corrupt a load in flight.
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cur_addr;
                    wr_data_d = in_data;
`ifdef KMEM_CHECKSUM_EN
                    checksum_d = checksum_q + 16'(in_data);
`endif
                    if (last_word) begin
                        state_d = S_DONE;
                        tap_d   = '0;
                        kern_d  = '0;
                    end else if (tap_q == TAP_LAST) begin
                        tap_d  = '0;
                        kern_d = kern_q + KERN_W'(1);
                    end else begin
                        tap_d = tap_q + TAP_W'(1);
                    end
                end
            end

            S_DONE: begin
                // done goes high one cycle after the final write, so the RAM holds every word when it is seen.
                done_d = 1'b1;
                if (start) begin
                    done_d  = 1'b0;
                    state_d = S_LOAD;
                    tap_d   = '0;
                    kern_d  = '0;
`ifdef KMEM_CHECKSUM_EN
                    checksum_d = 16'h0000;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any partial load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            tap_q     <= '0;
            kern_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            kern_q    <= kern_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
        end
    end

`ifdef KMEM_CHECKSUM_EN
    // Running sum of accepted words, frozen once the load completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= 16'h0000;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_en   = wr_en_q;
    assign done    = done_q;

endmodule

// File: tb/tb_conv2_k_mem_write.sv
module tb_conv2_k_mem_write;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        done;
    logic [15:0] checksum;

    int n_pass  = 0;
    int n_total = 0;

    conv2_k_mem_write #(
        .DATA_W  (8),
        .ADDR_W  (8),
        .KSIZE   (25),
        .NKERNELS(6)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .done    (done),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       vl;
        logic [7:0] dt;
        logic       rdy;   // in_ready before the edge
        logic       we;    // wr_en after the edge
        logic [7:0] adr;
        logic [7:0] wd;
        logic       dn;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input logic s, input logic v, input logic [7:0] d);
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_wr_en"},    wr_en,    0);
        chk({tag, "_wr_addr"},  wr_addr,  0);
        chk({tag, "_wr_data"},  wr_data,  0);
        chk({tag, "_done"},     done,     0);
        chk({tag, "_checksum"}, checksum, 0);
    endtask

    // Pulses start, then feeds n_words words and checks every write. Optionally pulses start again at word start_at.
    task automatic run_load(input int n_words, input bit rand_v, input bit all_ff,
                            input int start_at, output int sum);
        int         sent   = 0;
        int         writes = 0;
        int         cyc    = 0;
        logic       v;
        logic [7:0] d;
        sum = 0;
        step(1'b1, 1'b0, 8'h00);
        chk("start_ready", in_ready, 1);
        chk("start_done_clr", done, 0);
        chk("start_csum_clr", checksum, 0);
        while (writes < n_words && cyc < 3000) begin
            v = (sent < n_words) && (rand_v ? ($urandom_range(0, 1) == 1) : 1'b1);
            d = all_ff ? 8'hFF : sent[7:0];
            if (sent < n_words) chk("load_ready", in_ready, 1);
            step(sent == start_at, v, d);
            chk("load_wr_en", wr_en, v);
            if (v) begin
                chk("load_wr_addr", wr_addr, writes);
                chk("load_wr_data", wr_data, d);
                sum += d;
                sent++;
                writes++;
                if (writes == 150) chk("done_not_early", done, 0);
            end
            cyc++;
        end
        if (cyc >= 3000) begin
            n_total++;
            $display("FAIL load_timeout: wrote %0d of %0d words", writes, n_words);
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    function automatic logic [15:0] exp_csum(input int sum);
`ifdef KMEM_CHECKSUM_EN
        return sum[15:0];
`else
        return (sum > -1) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    initial begin
        int sum;

        tbl[0] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h00, 8'h11, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 8'h01, 8'h22, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 8'h02, 8'h33, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 8'h03, 8'h44, 1'b0};

        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Short table: valid in IDLE ignored, start, stalls, start ignored while loading.
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].rdy);
            step(tbl[i].st, tbl[i].vl, tbl[i].dt);
            chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].we);
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_wr_addr", i), wr_addr, tbl[i].adr);
                chk($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].wd);
            end
            chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
        end

        // Reset mid-stream, right after a write.
        step(1'b0, 1'b1, 8'h55);
        chk("mid_wr_addr", wr_addr, 4);
        #2 reset = 1'b0;
        #1 check_all_zero("midreset");
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;

        // Full back-to-back load.
        run_load(150, 1'b0, 1'b0, -1, sum);
        step(1'b0, 1'b0, 8'h00);
        chk("b2b_done", done, 1);
        chk("b2b_done_wr_en", wr_en, 0);
        chk("b2b_checksum", checksum, exp_csum(sum));

        // Load with randomly toggling valid.
        run_load(150, 1'b1, 1'b0, -1, sum);
        step(1'b0, 1'b0, 8'h00);
        chk("rand_done", done, 1);

        // start at word 40 ignored; valid after done ignored.
        run_load(150, 1'b0, 1'b0, 40, sum);
        step(1'b0, 1'b0, 8'h00);
        chk("s40_done", done, 1);
        chk("post_done_ready", in_ready, 0);
        step(1'b0, 1'b1, 8'hAB);
        chk("post_done_wr_en", wr_en, 0);
        chk("post_done_hold", done, 1);
        chk("post_done_csum_stable", checksum, exp_csum(sum));

        // Second start clears done; reset after word 60 then restart from 0.
        run_load(60, 1'b0, 1'b0, -1, sum);
        #2 reset = 1'b0;
        #1 check_all_zero("reset60");
        @(posedge clk);
        #1 reset = 1'b1;
        run_load(150, 1'b0, 1'b0, -1, sum);
        step(1'b0, 1'b0, 8'h00);
        chk("restart_done", done, 1);

        // All-0xFF load: checksum is 150*255 when enabled, zero otherwise.
        run_load(150, 1'b0, 1'b1, -1, sum);
        step(1'b0, 1'b0, 8'h00);
        chk("ff_done", done, 1);
        chk("ff_checksum", checksum, exp_csum(sum));
        step(1'b0, 1'b1, 8'h01);
        chk("ff_checksum_stable", checksum, exp_csum(sum));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
